dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EX/MEM stage and the data memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  stall, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output stall, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: IDLE -> WAIT -> RESP with pipeline stall.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses via rsp_err.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CntLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [AW-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        rspValid_q;
    logic        rspErr_q;
    logic [31:0] mem [DEPTH];
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mis_q;
`endif

    logic          acceptNow;
    logic          enterResp;
    logic          accWe;
    logic [AW-1:0] accIdx;
    logic [31:0]   accWdata;
    logic          accMis;

    wire unusedAddrBits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

    // With zero wait states the access happens on the accept edge, so the
    // live request fields feed the memory instead of the latched copies.
    always_comb begin
        acceptNow = (state_q == IDLE) && bus.req_valid;
        enterResp = (acceptNow && (WAIT_CYCLES == 0)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0));
        accWe     = (state_q == IDLE) ? bus.req_we : we_q;
        accIdx    = (state_q == IDLE) ? bus.req_addr[AW+1:2] : idx_q;
        accWdata  = (state_q == IDLE) ? bus.req_wdata : wdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        accMis    = (state_q == IDLE) ? (bus.req_addr[1:0] != 2'b00) : mis_q;
`else
        accMis    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rspValid_q <= enterResp;
            rspErr_q   <= enterResp && accMis;
            if (enterResp && !accMis) begin
                if (accWe) begin
                    mem[accIdx] <= accWdata;
                end else begin
                    rdata_q <= mem[accIdx];
                end
            end

            // RESP ignores req_valid: it still belongs to the retiring request.
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        idx_q   <= bus.req_addr[AW+1:2];
                        wdata_q <= bus.req_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                        mis_q   <= (bus.req_addr[1:0] != 2'b00);
`endif
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CntLoad;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall     = acceptNow || (state_q == WAIT);
    assign bus.rsp_valid = rspValid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rsp_err   = rspErr_q;

endmodule
